// File: rtl/dac5571_pkg.sv
// -----------------------------------------------------------------------------
// dac5571_pkg
// Shared definitions for the DAC5571 I2C target: FSM state encoding, the bit
// positions of the fields inside the two-byte DAC5571 frame, the default
// target address and a helper that builds the readback frame.
// -----------------------------------------------------------------------------
package dac5571_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_MS,
        ST_WR_MS_ACK,
        ST_WR_LS,
        ST_WR_LS_ACK,
        ST_RD_MS,
        ST_RD_MS_ACK,
        ST_RD_LS,
        ST_RD_LS_ACK,
        ST_IGNORE
    } state_t;

    // 7-bit target address, not left-shifted.
    localparam logic [6:0] DEFAULT_ADDR = 7'b1001_100;

    // MS byte = {2'b00, PD1, PD0, D7..D4}; LS byte = {D3..D0, 4'bxxxx}.
    localparam int PD_HI     = 5;
    localparam int PD_LO     = 4;
    localparam int MS_NIB_HI = 3;
    localparam int MS_NIB_LO = 0;
    localparam int LS_NIB_HI = 7;
    localparam int LS_NIB_LO = 4;

    // Readback frame {MS, LS} as transmitted MSB first.
    function automatic logic [15:0] read_frame(input logic [7:0] v, input logic [1:0] pd);
        return {2'b00, pd, v[7:4], v[3:0], 4'b0000};
    endfunction

endpackage

// File: rtl/dac5571_i2c_target_if.sv
// -----------------------------------------------------------------------------
// dac5571_i2c_if
// Two-wire I2C bus bundle.
//   scl : bus clock, driven by the master only (targets never stretch it)
//   sda : open-drain data line; every agent drives only 1'b0 or 1'bz
// The pull-up stands in for the board resistor so an undriven line reads 1.
// -----------------------------------------------------------------------------
interface dac5571_i2c_if;
    logic scl;
    wire  sda;

    pullup (sda);

    modport master (output scl, inout sda);
    modport slave  (input  scl, inout sda);
endinterface

// File: rtl/dac5571_i2c_target_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Conditions one asynchronous I2C line: 2-flop synchronizer followed by a
// counter glitch filter. The filtered level only changes after filt_len
// consecutive sclk samples disagree with it.
//   sclk, rst : system clock, synchronous active-high reset
//   line_in   : raw asynchronous pin level
//   level     : filtered level (resets to the idle-bus value 1)
//   rise/fall : one-cycle pulses, high in the cycle the filtered level changes
// -----------------------------------------------------------------------------
module i2c_line_filter #(
    parameter int unsigned filt_len = 3
) (
    input  logic sclk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [3:0] CNT_MAX = 4'(filt_len - 1);

    logic [1:0] sync;
    logic [3:0] cnt;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which the synchronizer
    // chain depends on.
    always_ff @(posedge sclk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/dac5571_i2c_target.sv
// -----------------------------------------------------------------------------
// dac5571_i2c_target
// I2C target emulating the DAC5571 two-byte write/read protocol.
//   sclk, rst  : system clock, synchronous active-high reset
//   bus        : I2C bus (scl in, sda open-drain)
//   voltage    : current 8-bit DAC code
//   pd_mode    : current power-down bits {PD1,PD0}
//   vol_valid  : one-cycle pulse when voltage/pd_mode take a new value
//   busy       : high while this target is addressed (START..STOP/NACK)
// Bus events come from filtered levels only. The SDA drive changes only on a
// filtered SCL falling edge, so it is stable through every SCL high phase.
// -----------------------------------------------------------------------------
module dac5571_i2c_target
    import dac5571_pkg::*;
#(
    parameter logic [6:0]  i2c_equi_addr = DEFAULT_ADDR,
    parameter int unsigned filt_len      = 3
) (
    input  logic        sclk,
    input  logic        rst,
    dac5571_i2c_if.slave bus,
    output logic [7:0]  voltage,
    output logic [1:0]  pd_mode,
    output logic        vol_valid,
    output logic        busy
);
    state_t      state, next_state;
    logic        scl_lvl, scl_rise, scl_fall;
    logic        sda_lvl, sda_rise, sda_fall;
    logic        start_det, stop_det, in_byte;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sr, rx_shift;
    logic [15:0] tx_sr, tx_nxt;
    logic [5:0]  shadow;
    logic        rw, nack, sda_oe, oe_nxt;

    i2c_line_filter #(.filt_len(filt_len)) u_scl_filt (
        .sclk(sclk), .rst(rst), .line_in(bus.scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.filt_len(filt_len)) u_sda_filt (
        .sclk(sclk), .rst(rst), .line_in(bus.sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign in_byte   = state inside {ST_ADDR, ST_WR_MS, ST_WR_LS, ST_RD_MS, ST_RD_LS};
    assign rx_shift  = {rx_sr[6:0], sda_lvl};
    assign bus.sda   = sda_oe ? 1'b0 : 1'bz;

    // State register.
    always_ff @(posedge sclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic. Byte states leave on the falling edge that ends the
    // 8th clock; ACK states leave on the falling edge that ends the 9th.
    always_comb begin
        next_state = state;
        if (start_det) begin
            next_state = ST_ADDR;
        end else if (stop_det) begin
            next_state = ST_IDLE;
        end else if (scl_fall) begin
            case (state)
                ST_ADDR:      if (bit_cnt == 4'd8)
                                  next_state = (rx_sr[7:1] == i2c_equi_addr) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  next_state = rw ? ST_RD_MS : ST_WR_MS;
                ST_WR_MS:     if (bit_cnt == 4'd8) next_state = ST_WR_MS_ACK;
                ST_WR_MS_ACK: next_state = ST_WR_LS;
                ST_WR_LS:     if (bit_cnt == 4'd8) next_state = ST_WR_LS_ACK;
                ST_WR_LS_ACK: next_state = ST_WR_MS;
                ST_RD_MS:     if (bit_cnt == 4'd8) next_state = ST_RD_MS_ACK;
                ST_RD_MS_ACK: next_state = nack ? ST_IGNORE : ST_RD_LS;
                ST_RD_LS:     if (bit_cnt == 4'd8) next_state = ST_RD_LS_ACK;
                ST_RD_LS_ACK: next_state = nack ? ST_IGNORE : ST_RD_MS;
                default:      next_state = state;
            endcase
        end
    end

    // Output logic: next SDA drive and TX shift register. Entering RD_MS from
    // outside RD_MS reloads a fresh snapshot, so a write landing mid-read
    // cannot disturb a byte already in flight.
    // NOTE: both outputs get a hold value first so no path through the
    // block leaves them unassigned, which would infer a latch.
    always_comb begin
        tx_nxt = tx_sr;
        oe_nxt = sda_oe;
        if (start_det || stop_det) begin
            oe_nxt = 1'b0;
        end else if (scl_fall) begin
            case (next_state)
                ST_ADDR_ACK, ST_WR_MS_ACK, ST_WR_LS_ACK: oe_nxt = 1'b1;
                ST_RD_MS: begin
                    tx_nxt = (state == ST_RD_MS) ? {tx_sr[14:0], 1'b0} : read_frame(voltage, pd_mode);
                    oe_nxt = ~tx_nxt[15];
                end
                ST_RD_LS: begin
                    tx_nxt = {tx_sr[14:0], 1'b0};
                    oe_nxt = ~tx_nxt[15];
                end
                default:  oe_nxt = 1'b0;
            endcase
        end
    end

    // Datapath: bit counter, shift registers, shadow byte and outputs.
    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            shadow    <= '0;
            rw        <= 1'b0;
            nack      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            voltage   <= '0;
            pd_mode   <= '0;
            vol_valid <= 1'b0;
        end else begin
            tx_sr     <= tx_nxt;
            sda_oe    <= oe_nxt;
            vol_valid <= 1'b0;

            if (start_det || stop_det || (scl_fall && next_state != state)) begin
                bit_cnt <= '0;
            end else if (scl_rise && in_byte) begin
                bit_cnt <= bit_cnt + 4'd1;
                rx_sr   <= rx_shift;
            end

            // The 8th sample of a write byte completes it; only a complete LS
            // byte commits the frame, so partial frames leave outputs alone.
            if (scl_rise && bit_cnt == 4'd7) begin
                if (state == ST_WR_MS) shadow <= rx_shift[PD_HI:MS_NIB_LO];
                if (state == ST_WR_LS) begin
                    voltage   <= {shadow[MS_NIB_HI:MS_NIB_LO], rx_shift[LS_NIB_HI:LS_NIB_LO]};
                    pd_mode   <= shadow[PD_HI:PD_LO];
                    vol_valid <= 1'b1;
                end
            end

            if (scl_rise && (state == ST_RD_MS_ACK || state == ST_RD_LS_ACK)) nack <= sda_lvl;
            if (state == ST_ADDR && next_state == ST_ADDR_ACK) rw <= rx_sr[0];

            if (next_state == ST_ADDR_ACK)                              busy <= 1'b1;
            else if (next_state == ST_IDLE || next_state == ST_IGNORE) busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dac5571_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_dac5571_i2c_target
// Bit-banged I2C master driving the DAC5571 target. Expected DAC updates are
// computed from the byte-level frame rules and queued; a monitor pops and
// compares whenever vol_valid pulses. ACKs, readback bytes and hold values
// are compared inline.
// -----------------------------------------------------------------------------
module tb_dac5571_i2c_target;
    localparam int         Q    = 10;       // quarter SCL period in sclk cycles
    localparam logic [6:0] ADDR = 7'h4C;

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] voltage;
    logic [1:0] pd_mode;
    logic       vol_valid, busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    logic [7:0] wbytes[$];
    logic [7:0] ref_v  = 8'h00;
    logic [1:0] ref_pd = 2'b00;
    bit         expect_not_busy = 1'b0;
    int         busy_viol = 0;
    logic       prev_vv = 1'b0;

    always #5 sclk = ~sclk;

    dac5571_i2c_if bus();
    assign bus.scl = m_scl;
    assign bus.sda = m_sda ? 1'bz : 1'b0;

    dac5571_i2c_target #(.i2c_equi_addr(ADDR), .filt_len(3)) dut (
        .sclk(sclk), .rst(rst), .bus(bus),
        .voltage(voltage), .pd_mode(pd_mode), .vol_valid(vol_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_q(input int n = 1);
        repeat (n * Q) @(negedge sclk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    // One SCL clock: set SDA while low, sample the bus mid-high.
    task automatic clock_bit(input logic b, output logic sampled);
        wait_q();
        m_sda = b;     wait_q();
        m_scl = 1'b1;  wait_q();
        sampled = bus.sda;
        wait_q();
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(nack_bit, s);
    endtask

    // Sends wbytes (address byte first) and models the frame at byte level.
    task automatic run_write(input bit do_stop);
        logic       ack, addressed;
        logic [7:0] ms, ls;
        logic [7:0] v;
        logic [1:0] pd;
        addressed = (wbytes[0][7:1] == ADDR) && !wbytes[0][0];
        i2c_start();
        for (int i = 0; i < wbytes.size(); i++) begin
            if (addressed && i >= 2 && (i % 2) == 0) begin
                ms = wbytes[i-1];
                ls = wbytes[i];
                pd = 2'((ms / 16) % 4);
                v  = 8'((ms % 16) * 16 + ls / 16);
                exp_q.push_back({pd, v});
                ref_v  = v;
                ref_pd = pd;
            end
            send_byte(wbytes[i], ack);
            check($sformatf("ack_byte%0d", i), 32'(ack), addressed ? 32'd0 : 32'd1);
            if (i == 0) check("busy_after_addr", 32'(busy), 32'(addressed));
        end
        if (do_stop) begin
            i2c_stop();
            wait_q();
            check("busy_after_stop", 32'(busy), 32'd0);
            check("voltage_after_stop", 32'(voltage), 32'(ref_v));
            check("pd_after_stop", 32'(pd_mode), 32'(ref_pd));
        end
    endtask

    task automatic run_read(input int n);
        logic       ack;
        logic [7:0] got, exp;
        i2c_start();
        send_byte({ADDR, 1'b1}, ack);
        check("ack_read_addr", 32'(ack), 32'd0);
        for (int i = 0; i < n; i++) begin
            exp = ((i % 2) == 0) ? 8'(ref_pd * 16 + ref_v / 16) : 8'((ref_v % 16) * 16);
            read_byte(i == n - 1, got);
            check($sformatf("read_byte%0d", i), 32'(got), 32'(exp));
        end
        wait_q();
        check("sda_released_after_nack", 32'(bus.sda), 32'd1);
        check("busy_after_nack", 32'(busy), 32'd0);
        i2c_stop();
    endtask

    // Scoreboard monitor: every vol_valid pulse must match the oldest expectation.
    always @(negedge sclk) begin
        if (!rst) begin
            if (vol_valid) begin
                check("vol_valid_single_cycle", 32'(prev_vv), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_vol_valid", 32'(vol_valid), 32'd0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("sb_voltage", 32'(voltage), 32'(e[7:0]));
                    check("sb_pd_mode", 32'(pd_mode), 32'(e[9:8]));
                end
            end
            if (expect_not_busy && busy) busy_viol++;
            prev_vv = vol_valid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       s, ack;
        logic [7:0] ms;
        int         r;
        logic [6:0] bad;

        repeat (5) @(negedge sclk);
        check("rst_voltage", 32'(voltage), 32'd0);
        check("rst_pd_mode", 32'(pd_mode), 32'd0);
        check("rst_vol_valid", 32'(vol_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sda", 32'(bus.sda), 32'd1);
        rst = 1'b0;
        repeat (10) @(negedge sclk);

        // Basic write 0x9A, PD=00.
        wbytes = {8'h98, 8'h09, 8'hA0};
        run_write(1'b1);

        // Wrong address: no ACK, no busy, outputs held.
        expect_not_busy = 1'b1;
        wbytes = {8'h9A, 8'h3F, 8'hF0};
        run_write(1'b1);
        expect_not_busy = 1'b0;
        check("busy_never_on_mismatch", 32'(busy_viol), 32'd0);

        // Partial frame: MS only, then STOP.
        wbytes = {8'h98, 8'h2F};
        run_write(1'b1);

        // Readback: MS, LS, MS (NACK).
        run_read(3);

        // Continuous frames.
        wbytes = {8'h98, 8'h01, 8'h00, 8'h3F, 8'hF0};
        run_write(1'b1);

        // Reset while the target drives the MS-byte ACK.
        i2c_start();
        send_byte(8'h98, ack);
        check("ack_before_rst", 32'(ack), 32'd0);
        ms = 8'h2B;
        for (int i = 7; i >= 0; i--) clock_bit(ms[i], s);
        m_sda = 1'b1;
        wait_q();
        check("ack_driven_before_rst", 32'(bus.sda), 32'd0);
        rst = 1'b1;
        @(posedge sclk); #1;
        check("sda_released_by_rst", 32'(bus.sda), 32'd1);
        check("voltage_after_rst", 32'(voltage), 32'd0);
        check("busy_after_rst", 32'(busy), 32'd0);
        ref_v  = 8'h00;
        ref_pd = 2'b00;
        repeat (4) @(negedge sclk);
        rst = 1'b0;
        repeat (4) @(negedge sclk);
        i2c_stop();
        wbytes = {8'h98, 8'h25, 8'h60};
        run_write(1'b1);

        // Randomized mix of writes, partial frames, reads, foreign addresses
        // and repeated STARTs.
        for (int it = 0; it < 15; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5 || r == 9) begin
                wbytes = {8'h98};
                for (int f = 0, nf = $urandom_range(1, 3); f < nf; f++) begin
                    wbytes.push_back(8'($urandom));
                    wbytes.push_back(8'($urandom));
                end
                if (r == 5) void'(wbytes.pop_back());
                run_write(r != 9);
                if (r == 9) begin
                    wbytes = {8'h98, 8'($urandom), 8'($urandom)};
                    run_write(1'b1);
                end
            end else if (r <= 7) begin
                run_read($urandom_range(1, 4));
            end else begin
                bad = 7'($urandom);
                if (bad == ADDR) bad = bad ^ 7'h01;
                busy_viol = 0;
                expect_not_busy = 1'b1;
                wbytes = {{bad, 1'b0}, 8'($urandom), 8'($urandom)};
                run_write(1'b1);
                expect_not_busy = 1'b0;
                check("busy_never_on_foreign_addr", 32'(busy_viol), 32'd0);
            end
        end

        wait_q(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
